hit_resolver: RTL
=================

Name: hit_resolver

Overview:
- Two-player combat resolver. Sits downstream of player_move and player_attack for both fighters, and upstream of player_state_anim.
- Once per frame (SCEN), tests each attacker's hitbox against the opponent's hurtbox and applies damage.
- Generates hitstun_active for each defender. Tracks health and KO.
- Replaces the constant-0 hitstun tie-off in the single-player top.

Parameters:
- MAX_HEALTH, 100, starting and reset health per player (fits 8 bits).
- DAMAGE, 10, health removed per landed hit.
- HITSTUN_FRAMES, 20, frames the defender stays in hitstun after a hit (1..63).
- CHIP_DAMAGE, 2, health removed on a blocked hit (used only with HIT_BLOCK_EN).

Ports:
- clk  in  1  pixel clock (25 MHz)
- reset  in  1  synchronous, active-high reset
- SCEN  in  1  frame tick; one-cycle pulse per frame
- pos_x_a, pos_y_a  in  10 each  player A sprite origin
- pos_x_b, pos_y_b  in  10 each  player B sprite origin
- facing_right_a, facing_right_b  in  1 each  facing direction
- attack_active_a, attack_active_b  in  1 each  attack animation in progress
- attack_damage_a, attack_damage_b  in  1 each  hitbox live window
- hit_pulse_a, hit_pulse_b  out  1 each  one-cycle pulse: that player was hit this frame
- hitstun_active_a, hitstun_active_b  out  1 each  defender in hitstun
- health_a, health_b  out  8 each  current health
- ko_a, ko_b  out  1 each  health reached 0 (sticky)
- round_over  out  1  ko_a OR ko_b, registered

Behaviour:
- Geometry, computed in 11-bit unsigned:
  - Hitbox: W=40, H=80.
    - Facing right: x0 = pos_x+85.
    - Facing left: x0 = pos_x-5, clamped to 0 if pos_x<5.
    - y0 = pos_y-5, clamped to 0.
  - Hurtbox: x0 = pos_x+40, W=40; y0 = pos_y+53, H=45.
  - Overlap (strict AABB): hx0<ux1 && ux0<hx1 && hy0<uy1 && uy0<hy1, where x1=x0+W and y1=y0+H.
  - Overlap logic is purely combinational.
- Armed flag per attacker:
  - Set when attack_active rises.
  - Cleared when that attacker lands a hit.
  - Cleared when attack_active falls.
  - Net effect: at most one hit per attack.
- Evaluation happens only on cycles with SCEN=1, using pre-update state. A hits B iff all of:
  - attack_damage_a, armed_a, overlap(A hitbox, B hurtbox)
  - !hitstun_b, !hitstun_a, !ko_a, !ko_b
  - B symmetric.
- Simultaneous hits (trade): both land in the same SCEN. Both take damage, both enter hitstun, both armed flags clear.
- On a hit:
  - health -= DAMAGE, saturating at 0.
  - Hitstun counter loaded with HITSTUN_FRAMES.
  - hit_pulse high for exactly one cycle.
  - All outputs update on the clk edge after SCEN (latency 1 cycle).
- Hitstun counter (6-bit, per player):
  - Decrements on each SCEN while nonzero; a load takes priority over the decrement.
  - hitstun_active = (counter != 0).
- KO:
  - ko set when health becomes 0 and stays set until reset.
  - While either player is KO, no further hits are accepted.
  - Hitstun timers keep draining.
- Reset (any cycle, including mid-hitstun):
  - health = MAX_HEALTH, counters = 0, armed = 0.
  - All pulses, ko and round_over = 0.
- No SCEN: state holds. attack_damage without SCEN has no effect.
- Per-player state machine: IDLE -> HITSTUN (on hit) -> IDLE (counter reaches 0). Any state -> KO (health 0); KO is terminal until reset.

Optional Feature:
- Macro: HIT_BLOCK_EN.
- When defined:
  - Adds input ports block_a and block_b (1 bit each; defender holding back).
  - A hit on a blocking defender applies CHIP_DAMAGE instead of DAMAGE and does not load hitstun.
  - hit_pulse still fires.
  - The attacker's armed flag still clears.
- When undefined: the block ports and CHIP_DAMAGE logic are absent, and every hit is a full hit.

Decomposition:
- Package fighter_pkg holds the shared geometry constants so the top-level debug overlay uses identical numbers:
  - HITBOX_W/H, HITBOX_XOFF_R (85), HITBOX_XOFF_L (5), HITBOX_YOFF (5)
  - HURTBOX_W/H, HURTBOX_XOFF (40), HURTBOX_YOFF (53)
- One sub-module, hit_overlap: combinational. Takes the attacker position/facing and the defender position; outputs overlap. Instantiated twice, A->B and B->A.

Test Plan:
- Full hit: A(200,280) facing right, B(260,280); raise attack_active_a then attack_damage_a; pulse SCEN -> next cycle hit_pulse_b=1 for one cycle, health_b=90, hitstun_active_b=1 for exactly 20 SCENs.
- Miss: B at pos_x=300 (hurtbox 340..380 vs hitbox 285..325) -> no pulse, health_b stays 100.
- One hit per attack: hold attack_damage_a across 7 SCENs in overlap -> health_b=90 only. Drop attack_active_a, start a new attack after hitstun ends -> health_b=80.
- Trade: A at 200 facing right, B at 250 facing left, both damage windows on the same SCEN -> health_a=health_b=90, both in hitstun.
- KO and reset: B at health 10 takes a hit -> health_b=0, ko_b=1, round_over=1; further hits ignored; assert reset mid-hitstun -> health 100/100, all flags 0 next cycle.
- HIT_BLOCK_EN: block_b=1 on a hit -> health_b=98, hitstun_active_b stays 0, hit_pulse_b pulses once.

Source files
------------

// File: rtl/hit_resolver_pkg.sv
// Shared fighter geometry constants, per-player state encoding and helpers.
// Imported by the resolver, the overlap test and the debug overlay so all use identical numbers.
package fighter_pkg;

    localparam int HITBOX_W      = 40;
    localparam int HITBOX_H      = 80;
    localparam int HITBOX_XOFF_R = 85;
    localparam int HITBOX_XOFF_L = 5;
    localparam int HITBOX_YOFF   = 5;

    localparam int HURTBOX_W     = 40;
    localparam int HURTBOX_H     = 45;
    localparam int HURTBOX_XOFF  = 40;
    localparam int HURTBOX_YOFF  = 53;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HITSTUN = 2'd1,
        ST_KO      = 2'd2
    } player_state_t;

    // Health never wraps below zero.
    function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

endpackage

// File: rtl/hit_resolver_if.sv
// Combat bus between the fighter pipeline and hit_resolver.
// Block inputs exist only when HIT_BLOCK_EN is defined.
interface hit_resolver_if;
    logic       SCEN;
    logic [9:0] pos_x_a;
    logic [9:0] pos_y_a;
    logic [9:0] pos_x_b;
    logic [9:0] pos_y_b;
    logic       facing_right_a;
    logic       facing_right_b;
    logic       attack_active_a;
    logic       attack_active_b;
    logic       attack_damage_a;
    logic       attack_damage_b;
`ifdef HIT_BLOCK_EN
    logic       block_a;
    logic       block_b;
`endif
    logic       hit_pulse_a;
    logic       hit_pulse_b;
    logic       hitstun_active_a;
    logic       hitstun_active_b;
    logic [7:0] health_a;
    logic [7:0] health_b;
    logic       ko_a;
    logic       ko_b;
    logic       round_over;

    modport master (
`ifdef HIT_BLOCK_EN
        output block_a, block_b,
`endif
        output SCEN, pos_x_a, pos_y_a, pos_x_b, pos_y_b,
        output facing_right_a, facing_right_b,
        output attack_active_a, attack_active_b, attack_damage_a, attack_damage_b,
        input  hit_pulse_a, hit_pulse_b, hitstun_active_a, hitstun_active_b,
        input  health_a, health_b, ko_a, ko_b, round_over
    );

    modport slave (
`ifdef HIT_BLOCK_EN
        input  block_a, block_b,
`endif
        input  SCEN, pos_x_a, pos_y_a, pos_x_b, pos_y_b,
        input  facing_right_a, facing_right_b,
        input  attack_active_a, attack_active_b, attack_damage_a, attack_damage_b,
        output hit_pulse_a, hit_pulse_b, hitstun_active_a, hitstun_active_b,
        output health_a, health_b, ko_a, ko_b, round_over
    );
endinterface

// File: rtl/hit_resolver_overlap.sv
// hit_overlap: combinational strict-AABB test of an attacker's hitbox against a defender's hurtbox.
// All box edges are formed in 11 bits so the right/bottom edges never wrap.
module hit_overlap
    import fighter_pkg::*;
(
    input  logic [9:0] atk_x,
    input  logic [9:0] atk_y,
    input  logic       atk_facing_right,
    input  logic [9:0] def_x,
    input  logic [9:0] def_y,
    output logic       overlap
);

    logic [10:0] hx0, hx1, hy0, hy1;
    logic [10:0] ux0, ux1, uy0, uy1;

    always_comb begin
        // Left-facing and vertical offsets clamp at the screen edge instead of wrapping.
        if (atk_facing_right)
            hx0 = {1'b0, atk_x} + 11'(HITBOX_XOFF_R);
        else if (atk_x < 10'(HITBOX_XOFF_L))
            hx0 = '0;
        else
            hx0 = {1'b0, atk_x} - 11'(HITBOX_XOFF_L);

        if (atk_y < 10'(HITBOX_YOFF))
            hy0 = '0;
        else
            hy0 = {1'b0, atk_y} - 11'(HITBOX_YOFF);

        hx1 = hx0 + 11'(HITBOX_W);
        hy1 = hy0 + 11'(HITBOX_H);

        ux0 = {1'b0, def_x} + 11'(HURTBOX_XOFF);
        uy0 = {1'b0, def_y} + 11'(HURTBOX_YOFF);
        ux1 = ux0 + 11'(HURTBOX_W);
        uy1 = uy0 + 11'(HURTBOX_H);

        overlap = (hx0 < ux1) && (ux0 < hx1) && (hy0 < uy1) && (uy0 < hy1);
    end

endmodule

// File: rtl/hit_resolver.sv
// Two-player hit resolver: per-frame hit tests, damage, hitstun timers, KO and round-over.
// Build option HIT_BLOCK_EN adds block inputs (chip damage, no hitstun on a blocked hit).
module hit_resolver
    import fighter_pkg::*;
#(
    parameter int MAX_HEALTH     = 100,
    parameter int DAMAGE         = 10,
    parameter int HITSTUN_FRAMES = 20
`ifdef HIT_BLOCK_EN
    ,
    parameter int CHIP_DAMAGE    = 2
`endif
) (
    input  logic           clk,
    input  logic           reset,
    hit_resolver_if.slave  bus
);

    localparam logic [7:0] HEALTH_INIT = 8'(MAX_HEALTH);
    localparam logic [7:0] DMG_FULL    = 8'(DAMAGE);
    localparam logic [5:0] STUN_LOAD   = 6'(HITSTUN_FRAMES);

    // Index 0 is player A, index 1 is player B.
    logic [9:0] pos_x [2];
    logic [9:0] pos_y [2];
    logic [1:0] facing;
    logic [1:0] active;
    logic [1:0] damage;
    logic [1:0] blk;

    assign pos_x[0] = bus.pos_x_a;
    assign pos_x[1] = bus.pos_x_b;
    assign pos_y[0] = bus.pos_y_a;
    assign pos_y[1] = bus.pos_y_b;
    assign facing   = {bus.facing_right_b, bus.facing_right_a};
    assign active   = {bus.attack_active_b, bus.attack_active_a};
    assign damage   = {bus.attack_damage_b, bus.attack_damage_a};
`ifdef HIT_BLOCK_EN
    assign blk      = {bus.block_b, bus.block_a};
`else
    assign blk      = 2'b00;
`endif

    logic [1:0] overlap;    // overlap[d]: opponent's hitbox touches player d's hurtbox
    logic [1:0] hit;        // hit[d]: player d is hit on this SCEN
    logic [1:0] armed;
    logic [1:0] stun_busy;
    logic [1:0] ko_now;
    logic [1:0] ko_next;
    logic [1:0] pulse;
    logic [7:0] health [2];
    logic       gate;
    logic       round_over_reg;

    // Any live hitstun or KO freezes all hit acceptance, using pre-update state.
    assign gate = ~|stun_busy & ~|ko_now;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_player
            localparam int OPP = 1 - gi;

            logic [7:0]    health_reg, health_next;
            logic [5:0]    stun_reg, stun_next;
            player_state_t state_reg, state_next;
            logic          armed_reg, armed_next;
            logic          attack_prev_reg;
            logic          pulse_reg;
            logic [7:0]    dmg_amount;
            logic          load_stun;

            hit_overlap u_overlap (
                .atk_x            (pos_x[OPP]),
                .atk_y            (pos_y[OPP]),
                .atk_facing_right (facing[OPP]),
                .def_x            (pos_x[gi]),
                .def_y            (pos_y[gi]),
                .overlap          (overlap[gi])
            );

            assign hit[gi] = bus.SCEN & damage[OPP] & armed[OPP] & overlap[gi] & gate;

`ifdef HIT_BLOCK_EN
            assign dmg_amount = blk[gi] ? 8'(CHIP_DAMAGE) : DMG_FULL;
            assign load_stun  = hit[gi] & ~blk[gi];
`else
            assign dmg_amount = DMG_FULL;
            assign load_stun  = hit[gi] & ~blk[gi];
`endif

            always_comb begin
                health_next = health_reg;
                stun_next   = stun_reg;
                state_next  = state_reg;

                if (hit[gi])
                    health_next = sat_sub8(health_reg, dmg_amount);

                if (load_stun)
                    stun_next = STUN_LOAD;
                else if (bus.SCEN && stun_reg != 6'd0)
                    stun_next = stun_reg - 6'd1;

                case (state_reg)
                    ST_KO: state_next = ST_KO;
                    default: begin
                        if (health_next == 8'd0)
                            state_next = ST_KO;
                        else if (stun_next != 6'd0)
                            state_next = ST_HITSTUN;
                        else
                            state_next = ST_IDLE;
                    end
                endcase
            end

            // Armed tracks this player's own attack; it is spent by landing on the opponent.
            always_comb begin
                armed_next = armed_reg;
                if (!active[gi])
                    armed_next = 1'b0;
                else if (!attack_prev_reg)
                    armed_next = 1'b1;
                else if (hit[OPP])
                    armed_next = 1'b0;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    health_reg      <= HEALTH_INIT;
                    stun_reg        <= '0;
                    state_reg       <= ST_IDLE;
                    armed_reg       <= 1'b0;
                    attack_prev_reg <= 1'b0;
                    pulse_reg       <= 1'b0;
                end else begin
                    health_reg      <= health_next;
                    stun_reg        <= stun_next;
                    state_reg       <= state_next;
                    armed_reg       <= armed_next;
                    attack_prev_reg <= active[gi];
                    pulse_reg       <= hit[gi];
                end
            end

            assign armed[gi]     = armed_reg;
            assign stun_busy[gi] = (stun_reg != 6'd0);
            assign ko_now[gi]    = (state_reg == ST_KO);
            assign ko_next[gi]   = (state_next == ST_KO);
            assign pulse[gi]     = pulse_reg;
            assign health[gi]    = health_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset)
            round_over_reg <= 1'b0;
        else
            round_over_reg <= |ko_next;
    end

    assign bus.hit_pulse_a      = pulse[0];
    assign bus.hit_pulse_b      = pulse[1];
    assign bus.hitstun_active_a = stun_busy[0];
    assign bus.hitstun_active_b = stun_busy[1];
    assign bus.health_a         = health[0];
    assign bus.health_b         = health[1];
    assign bus.ko_a             = ko_now[0];
    assign bus.ko_b             = ko_now[1];
    assign bus.round_over       = round_over_reg;

endmodule
